// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of imem_loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [7:0]        RxData;
    logic              RxValid;
    logic              RxReady;
    logic              ImWrEn;
    logic [ADDR_W-1:0] ImWrAddr;
    logic [31:0]       ImWrData;

    modport master (
        output RxData, RxValid,
        input  RxReady, ImWrEn, ImWrAddr, ImWrData
    );

    modport slave (
        input  RxData, RxValid,
        output RxReady, ImWrEn, ImWrAddr, ImWrData
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: byte frame (16-bit count + big-endian words) into instruction memory.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic         Clk,
    input  logic         Reset,
    imem_loader_if.slave bus,
    input  logic         Reload,
    output logic         CpuReset,
    output logic         Done,
    output logic         Error
);
    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StChk,
`endif
        StRun,
        StErr
    } state_t;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       MaxWords = 17'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t StAfterData = StChk;
`else
    localparam state_t StAfterData = StRun;
`endif

    state_t            state;
    logic [15:0]       count;
    logic [15:0]       word_idx;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              rx_ready;
    logic              accept;
    logic [15:0]       hdr_count;

    assign rx_ready     = (state != StRun) && (state != StErr);
    assign accept       = bus.RxValid && rx_ready;
    assign hdr_count    = {count[15:8], bus.RxData};
    assign bus.RxReady  = rx_ready;
    assign bus.ImWrEn   = wr_en;
    assign bus.ImWrAddr = wr_addr;
    assign bus.ImWrData = wr_data;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Covers CNT_HI through the last data byte; CNT_HI restarts the accumulation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            csum <= '0;
        end else if (state == StRun && Reload) begin
            csum <= '0;
        end else if (accept && state == StHdrHi) begin
            csum <= bus.RxData;
        end else if (accept && (state == StHdrLo || state == StData)) begin
            csum <= csum ^ bus.RxData;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= StHdrHi;
            count    <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= BaseAddr;
            wr_data  <= '0;
            CpuReset <= 1'b1;
            Done     <= 1'b0;
            Error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                StHdrHi: begin
                    if (accept) begin
                        count[15:8] <= bus.RxData;
                        state       <= StHdrLo;
                    end
                end
                StHdrLo: begin
                    if (accept) begin
                        count[7:0] <= bus.RxData;
                        if (hdr_count == 16'd0) begin
                            state <= StAfterData;
                        end else if ({1'b0, hdr_count} > MaxWords) begin
                            state <= StErr;
                            Error <= 1'b1;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        if (byte_cnt == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= BaseAddr + ADDR_W'(word_idx);
                            wr_data  <= {shift, bus.RxData};
                            word_idx <= word_idx + 16'd1;
                            byte_cnt <= 2'd0;
                            if (word_idx == count - 16'd1) state <= StAfterData;
                        end else begin
                            shift    <= {shift[15:0], bus.RxData};
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (accept) begin
                        if (bus.RxData == csum) begin
                            state <= StRun;
                        end else begin
                            state <= StErr;
                            Error <= 1'b1;
                        end
                    end
                end
`endif
                StRun: begin
                    // Release lags RUN entry by one edge so the last write lands first.
                    if (Reload) begin
                        state    <= StHdrHi;
                        count    <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        wr_addr  <= BaseAddr;
                        CpuReset <= 1'b1;
                        Done     <= 1'b0;
                    end else begin
                        CpuReset <= 1'b0;
                        Done     <= 1'b1;
                    end
                end
                StErr: begin
                    Error    <= 1'b1;
                    CpuReset <= 1'b1;
                end
                default: state <= StHdrHi;
            endcase
        end
    end
endmodule
